// File: rtl/counter_pkg.sv
// Shared types and next-count arithmetic for the counter block.
// Used by counter_next (and available to checker models); COUNTER_SAT_EN selects saturation in the RTL.
package counter_pkg;

  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e;

  localparam int CNT_WIDTH_DEF = 8;

  // Modular (or saturating) single step over 0..modulus-1; modulus is up to 2**32.
  function automatic logic [31:0] next_count(input logic [31:0] count,
                                             input cnt_dir_e  dir,
                                             input logic [32:0] modulus,
                                             input logic      sat);
    logic [32:0] top;
    logic [31:0] nxt;
    top = modulus - 33'd1;
    if (dir == CNT_UP) begin
      if ({1'b0, count} == top) nxt = sat ? count : 32'd0;
      else                      nxt = count + 32'd1;
    end else begin
      if (count == 32'd0)       nxt = sat ? 32'd0 : top[31:0];
      else                      nxt = count - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/counter_if.sv
// Bench-level grouping of the counter ports; clk and rst come in as interface ports.
interface counter_if #(parameter int WIDTH = 8) (input logic clk, input logic rst);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport dut (input clk, rst, en, up_dn, clr, load, load_val,
               output count, tc, wrap);
  modport tb  (input clk, rst, count, tc, wrap,
               output en, up_dn, clr, load, load_val);
endinterface

// File: rtl/counter_next.sv
// Combinational next count, wrap detect and terminal-count compare.
// With COUNTER_SAT_EN defined the step saturates and wrap is forced low.
module counter_next
  import counter_pkg::*;
#(
  parameter int              WIDTH   = CNT_WIDTH_DEF,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_up_dn,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

`ifdef COUNTER_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic w_at_max;
  logic w_at_zero;

  assign w_at_max  = (i_count == MAX);
  assign w_at_zero = (i_count == '0);
  // Explicit compares so a non-power-of-two modulus wraps correctly.
  assign o_tc      = i_up_dn ? w_at_max : w_at_zero;
  assign o_next    = WIDTH'(next_count(32'(i_count), cnt_dir_e'(i_up_dn), 33'(MODULUS), SAT));

`ifdef COUNTER_SAT_EN
  assign o_wrap = 1'b0;
`else
  assign o_wrap = o_tc;
`endif

endmodule

// File: rtl/counter.sv
// Up/down modulus counter with clear, parallel load, terminal count and wrap pulse.
// Optional macro COUNTER_SAT_EN: saturate instead of wrapping, plus runtime assertions.
module counter
  import counter_pkg::*;
#(
  parameter int              WIDTH   = CNT_WIDTH_DEF,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH,
  parameter longint unsigned RST_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RVAL = WIDTH'(RST_VAL);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("counter: WIDTH must be 2..32");
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("counter: MODULUS must be 2..2**WIDTH");
  end
  if (RST_VAL >= MODULUS) begin : g_bad_rst
    $error("counter: RST_VAL must be below MODULUS");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic             w_tc;
  logic [WIDTH-1:0] w_load;

  counter_next #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_next (
    .i_count (r_count),
    .i_up_dn (up_dn),
    .o_next  (w_next),
    .o_wrap  (w_wrap),
    .o_tc    (w_tc)
  );

  // Out-of-range load values clamp to the top of the range.
  assign w_load = (64'(load_val) >= MODULUS) ? MAX : load_val;

  // Priority rst > clr > load > en; the ternary lets an unknown en propagate X.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RVAL;
      r_wrap  <= 1'b0;
    end else if (clr) begin
      r_count <= RVAL;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= w_load;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= en ? w_next : r_count;
      r_wrap  <= en & w_wrap;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign tc    = w_tc;

`ifdef COUNTER_SAT_EN
  a_count_range: assert property (@(posedge clk) disable iff (rst) 64'(count) < MODULUS);
  a_ctrl_known:  assert property (@(posedge clk) !rst |-> !$isunknown({en, clr, load}));
`endif

endmodule

// File: tb/tb_counter.sv
// Randomized and directed bench for counter: a full-range (256) and a modulus-10 instance
// share stimulus and are compared every cycle against a plain-arithmetic model.
module tb_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, clr, load;
  logic [7:0] load_val;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_if #(.WIDTH(8)) ia (.clk(clk), .rst(rst));
  counter_if #(.WIDTH(8)) ib (.clk(clk), .rst(rst));

  assign ia.en = en;  assign ia.up_dn = up_dn;  assign ia.clr = clr;
  assign ia.load = load;  assign ia.load_val = load_val;
  assign ib.en = en;  assign ib.up_dn = up_dn;  assign ib.clr = clr;
  assign ib.load = load;  assign ib.load_val = load_val;

  counter #(.WIDTH(8), .MODULUS(64'd256), .RST_VAL(64'd0)) dut_a (
    .clk(clk), .rst(rst), .en(ia.en), .up_dn(ia.up_dn), .clr(ia.clr), .load(ia.load),
    .load_val(ia.load_val), .count(ia.count), .tc(ia.tc), .wrap(ia.wrap));

  counter #(.WIDTH(8), .MODULUS(64'd10), .RST_VAL(64'd0)) dut_b (
    .clk(clk), .rst(rst), .en(ib.en), .up_dn(ib.up_dn), .clr(ib.clr), .load(ib.load),
    .load_val(ib.load_val), .count(ib.count), .tc(ib.tc), .wrap(ib.wrap));

  // Reference model: counts live in 0..M-1, stepping with modular arithmetic.
  int unsigned m_mod [2] = '{256, 10};
  int unsigned m_cnt [2];
  int unsigned m_wrap[2];

`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  function automatic void model_edge(int k);
    int unsigned m = m_mod[k];
    int unsigned c = m_cnt[k];
    if (rst || clr) begin
      m_cnt[k] = 0;  m_wrap[k] = 0;
    end else if (load) begin
      m_cnt[k] = (int'(load_val) < int'(m)) ? int'(load_val) : m - 1;
      m_wrap[k] = 0;
    end else if (en) begin
      if (up_dn) begin
        if (SAT && c == m - 1) m_cnt[k] = c;
        else                   m_cnt[k] = (c + 1) % m;
        m_wrap[k] = (!SAT && c == m - 1) ? 1 : 0;
      end else begin
        if (SAT && c == 0) m_cnt[k] = 0;
        else               m_cnt[k] = (c + m - 1) % m;
        m_wrap[k] = (!SAT && c == 0) ? 1 : 0;
      end
    end else begin
      m_wrap[k] = 0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int unsigned ta, tb;
    ta = up_dn ? ((m_cnt[0] == m_mod[0] - 1) ? 1 : 0) : ((m_cnt[0] == 0) ? 1 : 0);
    tb = up_dn ? ((m_cnt[1] == m_mod[1] - 1) ? 1 : 0) : ((m_cnt[1] == 0) ? 1 : 0);
    check("a_count", 32'(ia.count), m_cnt[0]);
    check("a_wrap",  32'(ia.wrap),  m_wrap[0]);
    check("a_tc",    32'(ia.tc),    ta);
    check("b_count", 32'(ib.count), m_cnt[1]);
    check("b_wrap",  32'(ib.wrap),  m_wrap[1]);
    check("b_tc",    32'(ib.tc),    tb);
  endtask

  // One clock: model takes the edge with the inputs currently driven, outputs checked 1ns later.
  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic e, input logic u,
                       input logic c, input logic l, input logic [7:0] v);
    rst = r;  en = e;  up_dn = u;  clr = c;  load = l;  load_val = v;
  endtask

  initial begin
    m_cnt  = '{0, 0};
    m_wrap = '{0, 0};
    drive(1, 1, 1, 0, 0, 8'd0);

    // Reset held two cycles with en high
    cycle();
    cycle();
    check("rst_count", 32'(ia.count), 32'd0);
    check("rst_wrap",  32'(ia.wrap),  32'd0);
    drive(0, 1, 1, 0, 0, 8'd0);
    cycle();
    check("first_step", 32'(ia.count), 32'd1);

    // Ten runs of five up steps from zero
    drive(0, 0, 1, 1, 0, 8'd0);
    cycle();
    for (int r = 0; r < 10; r++) begin
      drive(0, 1, 1, 0, 0, 8'd0);
      for (int i = 0; i < 5; i++) cycle();
      drive(0, 0, 1, 0, 0, 8'd0);
      cycle();
    end
    check("run_50", 32'(ia.count), 32'd50);

    // Wrap at the top of the full range
    drive(0, 0, 1, 0, 1, 8'd254);
    cycle();
    drive(0, 1, 1, 0, 0, 8'd0);
    for (int i = 0; i < 3; i++) cycle();

    // Down from zero and back up (modulus 10)
    drive(0, 0, 0, 1, 0, 8'd0);
    cycle();
    drive(0, 1, 0, 0, 0, 8'd0);
    cycle();
    drive(0, 1, 1, 0, 0, 8'd0);
    cycle();

    // Priority: clr beats load beats en
    drive(0, 1, 1, 1, 1, 8'd7);
    cycle();
    check("prio_clr", 32'(ia.count), 32'd0);
    drive(0, 1, 1, 0, 1, 8'd7);
    cycle();
    check("prio_load", 32'(ia.count), 32'd7);
    drive(0, 1, 1, 0, 1, 8'd200);
    cycle();
    check("load_clamp", 32'(ib.count), 32'd9);

    // Reset mid-count
    drive(0, 0, 1, 0, 1, 8'd37);
    cycle();
    drive(1, 1, 1, 0, 0, 8'd0);
    cycle();
    check("rst_mid", 32'(ia.count), 32'd0);

    // Saturation / wrap at the top from 255
    drive(0, 0, 1, 0, 1, 8'd255);
    cycle();
    drive(0, 1, 1, 0, 0, 8'd0);
    cycle();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 50) == 0, ($urandom % 4) != 0, 1'($urandom),
            ($urandom % 20) == 0, ($urandom % 8) == 0, 8'($urandom));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
